// File: rtl/uart_rx_fifo_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | uart_rx_fifo_if: receiver-side capture and host FWFT read bundle      |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
interface uart_rx_fifo_if #(
  parameter int wordSize  = 8,
  parameter int addrWidth = 3
);
  logic [wordSize-1:0]  rxDatareg;
  logic                 received;
  logic                 error;
  logic                 notReady;
  logic [wordSize-1:0]  rdData;
  logic                 rdValid;
  logic                 rdReady;
  logic [addrWidth:0]   count;
  logic                 overrun;
  logic                 frameErr;
  logic                 clrStatus;

  // FIFO side
  modport slave (
    input  rxDatareg, received, error, rdReady, clrStatus,
    output notReady, rdData, rdValid, count, overrun, frameErr
  );

  // Receiver/host side
  modport master (
    output rxDatareg, received, error, rdReady, clrStatus,
    input  notReady, rdData, rdValid, count, overrun, frameErr
  );
endinterface
`default_nettype wire

// File: rtl/uart_rx_fifo.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | uart_rx_fifo: edge-captured UART words into a circular FWFT FIFO      |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module uart_rx_fifo #(
  parameter int wordSize  = 8,
  parameter int depth     = 8,
  parameter int addrWidth = 3
) (
  input  logic            sampleClk,
  input  logic            rst_b,
  uart_rx_fifo_if.slave   bus
);
  localparam logic [addrWidth:0] DEPTH_CNT = (addrWidth+1)'(depth);

  logic [wordSize-1:0]  mem_q [depth];
  logic [addrWidth-1:0] wrPtr_q, wrPtr_d;
  logic [addrWidth-1:0] rdPtr_q, rdPtr_d;
  logic [addrWidth:0]   count_q, count_d;
  logic                 recv_q, err_q;
  logic                 overrun_q, overrun_d;
  logic                 frameErr_q, frameErr_d;

  logic pushReq, errEvt, pop, push, full;

  assign full    = (count_q == DEPTH_CNT);
  assign pushReq = bus.received & ~recv_q;
  assign errEvt  = bus.error & ~err_q;
  assign pop     = (count_q != '0) & bus.rdReady;
  // A full FIFO still accepts a word when the head leaves in the same cycle
  assign push    = pushReq & (~full | pop);

  always_comb begin
    wrPtr_d    = push ? wrPtr_q + 1'b1 : wrPtr_q;
    rdPtr_d    = pop  ? rdPtr_q + 1'b1 : rdPtr_q;
    count_d    = count_q;
    case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
    overrun_d  = overrun_q;
    if (pushReq & ~push)  overrun_d = 1'b1;
    else if (bus.clrStatus) overrun_d = 1'b0;
    frameErr_d = frameErr_q;
    if (errEvt)           frameErr_d = 1'b1;
    else if (bus.clrStatus) frameErr_d = 1'b0;
  end

  always_ff @(posedge sampleClk or negedge rst_b) begin
    if (!rst_b) begin
      wrPtr_q    <= '0;
      rdPtr_q    <= '0;
      count_q    <= '0;
      recv_q     <= 1'b0;
      err_q      <= 1'b0;
      overrun_q  <= 1'b0;
      frameErr_q <= 1'b0;
    end else begin
      wrPtr_q    <= wrPtr_d;
      rdPtr_q    <= rdPtr_d;
      count_q    <= count_d;
      recv_q     <= bus.received;
      err_q      <= bus.error;
      overrun_q  <= overrun_d;
      frameErr_q <= frameErr_d;
    end
  end

  // Storage is deliberately left unreset
  always_ff @(posedge sampleClk) begin
    if (push) mem_q[wrPtr_q] <= bus.rxDatareg;
  end

  assign bus.rdData   = mem_q[rdPtr_q];
  assign bus.rdValid  = (count_q != '0);
  assign bus.notReady = full;
  assign bus.count    = count_q;
  assign bus.overrun  = overrun_q;
  assign bus.frameErr = frameErr_q;
endmodule
`default_nettype wire

// File: tb/tb_uart_rx_fifo.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_uart_rx_fifo: directed plan plus random traffic vs queue model     |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module tb_uart_rx_fifo;
  logic sampleClk = 1'b0;
  logic rst_b     = 1'b0;
  always #5 sampleClk = ~sampleClk;

  uart_rx_fifo_if #(.wordSize(8), .addrWidth(3)) bus();

  uart_rx_fifo #(.wordSize(8), .depth(8), .addrWidth(3)) dut (
    .sampleClk (sampleClk),
    .rst_b     (rst_b),
    .bus       (bus)
  );

  int errors = 0;
  int checks = 0;

  // Reference model: a queue of words plus sticky flags
  logic [7:0] mq[$];
  logic       m_recv, m_err, m_ovr, m_ferr;

  initial begin
    forever begin
      @(posedge sampleClk or negedge rst_b);
      if (!rst_b) begin
        mq.delete();
        m_recv = 1'b0; m_err = 1'b0; m_ovr = 1'b0; m_ferr = 1'b0;
      end else begin
        automatic bit req  = bus.received && !m_recv;
        automatic bit ev   = bus.error && !m_err;
        automatic bit popm = (mq.size() != 0) && bus.rdReady;
        automatic bit pshm = req && ((mq.size() < 8) || popm);
        if (popm) void'(mq.pop_front());
        if (pshm) mq.push_back(bus.rxDatareg);
        if (req && !pshm)        m_ovr  = 1'b1;
        else if (bus.clrStatus)  m_ovr  = 1'b0;
        if (ev)                  m_ferr = 1'b1;
        else if (bus.clrStatus)  m_ferr = 1'b0;
        m_recv = bus.received;
        m_err  = bus.error;
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Per-cycle compare against the model, away from the active edge
  initial begin
    forever begin
      @(negedge sampleClk);
      check("m_count",    32'(bus.count),    32'(mq.size()));
      check("m_rdValid",  32'(bus.rdValid),  32'(mq.size() != 0));
      check("m_notReady", 32'(bus.notReady), 32'(mq.size() == 8));
      check("m_overrun",  32'(bus.overrun),  32'(m_ovr));
      check("m_frameErr", 32'(bus.frameErr), 32'(m_ferr));
      if (mq.size() != 0) check("m_rdData", 32'(bus.rdData), 32'(mq[0]));
    end
  end

  task automatic tick();
    @(posedge sampleClk);
    #1;
  endtask

  task automatic push_word(input logic [7:0] d);
    bus.rxDatareg = d; bus.received = 1'b1; tick();
    bus.received = 1'b0; tick();
  endtask

  task automatic pop_one();
    bus.rdReady = 1'b1; tick();
    bus.rdReady = 1'b0;
  endtask

  initial begin
    bus.rxDatareg = '0; bus.received = 1'b0; bus.error = 1'b0;
    bus.rdReady = 1'b0; bus.clrStatus = 1'b0;
    #23 rst_b = 1'b1;
    tick();
    check("rst_count",    32'(bus.count),    0);
    check("rst_rdValid",  32'(bus.rdValid),  0);
    check("rst_notReady", 32'(bus.notReady), 0);
    check("rst_overrun",  32'(bus.overrun),  0);
    check("rst_frameErr", 32'(bus.frameErr), 0);

    // single word, one-cycle latency
    bus.rxDatareg = 8'hA5; bus.received = 1'b1; tick();
    bus.received = 1'b0;
    check("t1_valid", 32'(bus.rdValid), 1);
    check("t1_data",  32'(bus.rdData),  32'hA5);
    check("t1_count", 32'(bus.count),   1);
    pop_one();
    check("t1_empty", 32'(bus.rdValid), 0);
    check("t1_count0", 32'(bus.count),  0);

    // held level gives one push
    bus.rxDatareg = 8'h3C; bus.received = 1'b1;
    repeat (5) tick();
    bus.received = 1'b0; tick();
    check("t2_count", 32'(bus.count), 1);
    pop_one();

    // fill, overrun, drain
    for (int i = 1; i <= 8; i++) push_word(8'(i));
    check("t3_count",    32'(bus.count),    8);
    check("t3_notReady", 32'(bus.notReady), 1);
    push_word(8'h09);
    check("t3_overrun",  32'(bus.overrun),  1);
    check("t3_count9",   32'(bus.count),    8);
    for (int i = 1; i <= 8; i++) begin
      check("t3_drain", 32'(bus.rdData), 32'(i));
      pop_one();
    end
    check("t3_empty", 32'(bus.rdValid), 0);
    bus.clrStatus = 1'b1; tick(); bus.clrStatus = 1'b0;
    check("t3_clr", 32'(bus.overrun), 0);

    // push into full with simultaneous pop
    for (int i = 0; i < 8; i++) push_word(8'h61 + 8'(i));
    bus.rxDatareg = 8'h55; bus.received = 1'b1; bus.rdReady = 1'b1; tick();
    bus.received = 1'b0; bus.rdReady = 1'b0;
    check("t4_count",   32'(bus.count),   8);
    check("t4_overrun", 32'(bus.overrun), 0);
    for (int i = 0; i < 7; i++) begin
      check("t4_drain", 32'(bus.rdData), 32'(8'h62 + 8'(i)));
      pop_one();
    end
    check("t4_last", 32'(bus.rdData), 32'h55);
    pop_one();

    // wrap-around
    for (int i = 0; i < 20; i++) begin
      push_word(8'h10 + 8'(i));
      check("t5_data", 32'(bus.rdData), 32'(8'h10 + 8'(i)));
      pop_one();
    end
    check("t5_count", 32'(bus.count), 0);

    // framing error and clear priority
    bus.error = 1'b1; tick(); bus.error = 1'b0; tick();
    check("t6_ferr",  32'(bus.frameErr), 1);
    check("t6_count", 32'(bus.count),    0);
    bus.error = 1'b1; bus.clrStatus = 1'b1; tick();
    check("t6_setwins", 32'(bus.frameErr), 1);
    bus.error = 1'b0; tick(); bus.clrStatus = 1'b0;
    check("t6_cleared", 32'(bus.frameErr), 0);

    // asynchronous reset mid-stream
    push_word(8'hD1); push_word(8'hD2); push_word(8'hD3);
    check("t6_count3", 32'(bus.count), 3);
    #2 rst_b = 1'b0;
    #1;
    check("t6_rst_count", 32'(bus.count),   0);
    check("t6_rst_valid", 32'(bus.rdValid), 0);
    @(negedge sampleClk); rst_b = 1'b1;
    tick();

    // random traffic, model checks every cycle
    for (int c = 0; c < 3000; c++) begin
      bus.rxDatareg = 8'($urandom);
      bus.received  = ($urandom_range(0, 99) < 45);
      bus.error     = ($urandom_range(0, 99) < 8);
      bus.rdReady   = ($urandom_range(0, 99) < ((c / 500) % 2 == 0 ? 30 : 70));
      bus.clrStatus = ($urandom_range(0, 99) < 5);
      tick();
    end
    bus.received = 1'b0; bus.error = 1'b0; bus.rdReady = 1'b0; bus.clrStatus = 1'b0;
    tick(); tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
`default_nettype wire

// File: doc/uart_rx_fifo.md
Name: uart_rx_fifo

Overview:
Receive-side buffer directly downstream of the UART receiver. Captures each completed word from the receiver's parallel data output when its received flag rises, and holds the words in a circular FIFO. Presents them to the host through a valid/ready first-word-fall-through interface. Back-pressures the receiver through notReady, and records overrun and framing errors as sticky status bits.

Parameters:
wordSize, 8, width of one received data word (matches the receiver's wordSize)
depth, 8, number of FIFO entries; power of two, at least 2
addrWidth, 3, log2(depth); pointer width

Ports:
sampleClk  input  1  single clock shared with the UART receiver
rst_b  input  1  asynchronous active-low reset
rxDatareg  input  wordSize  parallel word from the receiver; valid while received is high
received  input  1  receiver word-complete flag; each rising edge is one word
error  input  1  receiver framing-error flag; each rising edge is one error event
notReady  output  1  back-pressure to the receiver; high when the FIFO is full
rdData  output  wordSize  head-of-FIFO word; combinational from storage
rdValid  output  1  FIFO not empty
rdReady  input  1  host accepts rdData this cycle
count  output  addrWidth+1  number of stored words, 0..depth
overrun  output  1  sticky; a word arrived while the FIFO was full and no pop occurred
frameErr  output  1  sticky; the receiver flagged a framing error
clrStatus  input  1  synchronous clear of overrun and frameErr

Behaviour:
- Reset (async, rst_b=0): wrPtr=0, rdPtr=0, count=0, overrun=0, frameErr=0, recvQ=0, errQ=0. Outputs: rdValid=0, notReady=0, rdData=mem[0] (contents undefined; storage is not reset).
- Edge detect: recvQ<=received and errQ<=error on every clock. Define pushReq = received & ~recvQ and errEvt = error & ~errQ.
  - A received level that is high when reset releases counts as one edge.
  - A received level held high for many cycles yields exactly one push.
- pop = rdValid & rdReady.
- push = pushReq & (count<depth | pop).
  - A push into a full FIFO is allowed only when a pop occurs in the same cycle.
- Write: on push, mem[wrPtr]<=rxDatareg, then wrPtr<=wrPtr+1. The pointer wraps modulo depth (natural addrWidth wrap).
- Read: on pop, rdPtr<=rdPtr+1 with the same wrap.
- count update:
  - push & ~pop: +1
  - pop & ~push: -1
  - push & pop: unchanged
  - count never exceeds depth and never underflows.
- rdValid = (count!=0). notReady = (count==depth). Both are derived combinationally from registered count.
- Latency: a word pushed at edge N is visible on rdData with rdValid=1 in the cycle after edge N (one cycle).
- Popping at edge N exposes the next word, or drops rdValid, right after edge N. Back-to-back pops at one word per cycle are supported.
- Overrun: pushReq & ~push sets overrun<=1. The incoming word is dropped and FIFO contents and pointers are unchanged.
- Framing error: errEvt sets frameErr<=1. A framing error never pushes data by itself; a word whose received edge coincides with errEvt is still pushed.
- clrStatus clears overrun and frameErr. If a set event occurs in the same cycle, the set wins (flag stays 1).
- Ordering: strict FIFO order; no reordering or duplication.
- Reset mid-operation: all state returns to reset values immediately (asynchronous) and buffered words are discarded.

Test Plan:
1. Reset, then one received pulse with rxDatareg=0xA5 -> next cycle rdValid=1, rdData=0xA5, count=1. Pulse rdReady for one cycle -> rdValid=0, count=0.
2. received held high 5 cycles with data 0x3C -> exactly one word stored, count=1.
3. Push 8 words 0x01..0x08 with rdReady=0 -> count=8, notReady=1. A 9th push of 0x09 -> overrun=1, count stays 8. Drain -> reads 0x01..0x08 in order.
4. With the FIFO full, push 0x55 in the same cycle as a pop -> count stays 8, overrun=0, and 0x55 is read last.
5. Wrap-around: alternate push/pop of 20 words 0x10..0x23 -> every word read back in order, count returns to 0, pointers wrap without loss.
6. error pulse -> frameErr=1, count unchanged. clrStatus together with a new error edge -> frameErr stays 1. clrStatus alone -> frameErr=0. Assert rst_b=0 mid-stream with count=3 -> count=0, rdValid=0 immediately.
